sdram_frame_writer: RTL and testbench
=====================================

Name: sdram_frame_writer

Overview:
Pixel-stream to SDRAM write-burst adapter that sits directly upstream of the SDRAM controller. It accepts 16-bit RGB565 words from the camera capture stage and buffers them in an internal FIFO. When a full burst is buffered, it requests a write from the controller and supplies the data beats. It also keeps a linear frame address that wraps once per frame.

Parameters:
BURST_LEN, 8, words per write burst; power of 2.
FIFO_DEPTH, 64, FIFO entries; power of 2, at least 2*BURST_LEN.
ADDR_W, 24, SDRAM word-address width.
BASE_ADDR, 0, word address of the first pixel in the frame.
FRAME_WORDS, 76800, words per frame (320x240); a multiple of BURST_LEN.

Ports:
sys_clk  in  1  single clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
pix_valid  in  1  pix_data is valid this cycle.
pix_data  in  16  RGB565 pixel.
frame_start  in  1  one-cycle pulse; the coincident pixel (if any) is pixel 0 of a new frame.
sdram_wr_req  out  1  burst write request; held until acked.
sdram_wr_addr  out  ADDR_W  burst start word address; stable while sdram_wr_req is high.
sdram_wr_ack  in  1  controller accepts the request this cycle.
sdram_wr_data  out  16  current beat (show-ahead).
sdram_wr_next  in  1  controller consumed sdram_wr_data this cycle.
frame_done  out  1  one-cycle pulse after the last burst of a frame completes.
overflow  out  1  sticky: a pixel was dropped.
fifo_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, released synchronously to sys_clk):
  - state=IDLE, FIFO empty, address=BASE_ADDR.
  - All outputs 0; sdram_wr_addr=BASE_ADDR.
- FIFO:
  - Push on pix_valid when not full.
  - Pop on sdram_wr_next in DATA while not aborting.
  - Push and pop in the same cycle when full are both performed; level unchanged.
  - pix_valid while full with no pop: pixel dropped, overflow set.
  - overflow clears only on rst or frame_start.
  - fifo_level is registered and reflects pushes/pops of the previous edge.
- FSM IDLE -> REQ:
  - Taken when fifo_level >= BURST_LEN.
  - sdram_wr_req goes high the cycle after that condition is registered.
- FSM REQ:
  - sdram_wr_req=1, sdram_wr_addr=current address.
  - On sdram_wr_ack: go to DATA, sdram_wr_req=0 next cycle, beat counter=0.
- FSM DATA:
  - sdram_wr_data = FIFO head, combinationally valid throughout DATA.
  - Each sdram_wr_next pops one word and increments the beat counter.
  - sdram_wr_next outside DATA is ignored.
  - After BURST_LEN beats: address += BURST_LEN, go to IDLE.
  - If the new address equals BASE_ADDR+FRAME_WORDS, the address becomes BASE_ADDR and frame_done pulses one cycle.
  - A back-to-back burst may return to REQ from IDLE on the very next cycle.
- frame_start in IDLE or REQ:
  - FIFO flushed, address=BASE_ADDR, overflow cleared, state=IDLE, sdram_wr_req dropped next cycle.
  - If sdram_wr_ack coincides in REQ, the ack wins: enter DATA in abort mode (see below).
- frame_start in DATA (or coincident with an ack):
  - FIFO flushed, address for the next burst = BASE_ADDR, abort flag set.
  - Remaining beats of the in-flight burst output 16'h0000 with no pops, so the controller always receives exactly BURST_LEN beats.
  - No frame_done is generated for an aborted burst; the abort flag clears at burst end.
- Pixel coincident with frame_start: written after the flush as FIFO entry 0.
- Width rules:
  - Address arithmetic is ADDR_W bits, unsigned.
  - The beat counter is log2(BURST_LEN) bits.
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits, with full/empty decided by the MSB.

Test Plan:
- Reset release, then 8 pixels 0x0001..0x0008 on consecutive cycles -> sdram_wr_req rises with addr 0; after ack, 8 sdram_wr_next yield data 0x0001..0x0008; fifo_level returns to 0; next burst addr=8.
- Stream FRAME_WORDS=64 (param override) pixels with immediate acks -> 8 bursts at addrs 0,8,...,56; frame_done pulses once after the last beat; next burst addr=0.
- Hold sdram_wr_ack low while pushing 70 pixels -> fifo_level saturates at 64, overflow=1, pixels 65..70 absent from later readout; frame_start clears overflow.
- frame_start after 3 of 8 beats -> beats 4..8 read 0x0000, next burst addr=BASE_ADDR, the pixel coincident with frame_start is the first data of that burst.
- Full FIFO with simultaneous push and sdram_wr_next -> level stays 64, no overflow, ordering preserved.
- Assert rst mid-DATA -> sdram_wr_req=0, fifo_level=0, sdram_wr_addr=BASE_ADDR immediately (async), FSM restarts cleanly after release.

Source files
------------

// File: rtl/sdram_frame_writer.sv
// Pixel-stream to SDRAM write-burst adapter.
// Buffers RGB565 words in a FIFO, issues a write request once a full burst is
// held, streams the beats show-ahead and advances a per-frame linear address.
module sdram_frame_writer #(
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 64,
    parameter int          ADDR_W      = 24,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 76800
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic [15:0]                   pix_data,
    input  logic                          frame_start,
    output logic                          sdram_wr_req,
    output logic [ADDR_W-1:0]             sdram_wr_addr,
    input  logic                          sdram_wr_ack,
    output logic [15:0]                   sdram_wr_data,
    input  logic                          sdram_wr_next,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(BASE_ADDR + FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t            state, state_nxt;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [BW-1:0]     beat;
    logic [ADDR_W-1:0] addr;
    logic              abort;

    logic              full, pop, push, wr_en, burst_end, abort_start;
    logic [AW-1:0]     wr_idx;
    logic [ADDR_W-1:0] addr_inc;

    // Pointer MSBs differ with equal low bits -> wrapped once -> full.
    assign full        = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    // An aborting burst emits filler beats, so nothing is consumed.
    assign pop         = (state == DATA) && sdram_wr_next && !abort;
    assign push        = pix_valid && (!full || pop);
    assign burst_end   = (state == DATA) && sdram_wr_next && (beat == BW'(BURST_LEN - 1));
    // A frame restart landing on a live burst (or on its ack) must still let
    // the controller finish its BURST_LEN beats.
    assign abort_start = frame_start && ((state == DATA) || (state == REQ && sdram_wr_ack));
    // A flush rewinds both pointers; a coincident pixel becomes entry 0.
    assign wr_en       = frame_start ? pix_valid : push;
    assign wr_idx      = frame_start ? '0 : wp[AW-1:0];
    assign addr_inc    = addr + ADDR_W'(BURST_LEN);

    assign sdram_wr_req  = (state == REQ);
    assign sdram_wr_addr = addr;
    assign sdram_wr_data = (state == DATA && !abort) ? mem[rp[AW-1:0]] : 16'h0000;

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: request once a burst is buffered, ack wins over restart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!frame_start && fifo_level >= PW'(BURST_LEN)) state_nxt = REQ;
            REQ:  if (sdram_wr_ack)     state_nxt = DATA;
                  else if (frame_start) state_nxt = IDLE;
            DATA: if (burst_end)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset, pointers define validity.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_idx] <= pix_data;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else if (frame_start) begin
            wp         <= PW'(pix_valid);
            rp         <= '0;
            fifo_level <= PW'(pix_valid);
            overflow   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            if (pix_valid && !push) overflow <= 1'b1;
        end
    end

    // Beat counter, abort flag, frame address and end-of-frame pulse.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            abort      <= 1'b0;
            addr       <= BASE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state == REQ && sdram_wr_ack)        beat <= '0;
            else if (state == DATA && sdram_wr_next) beat <= beat + 1'b1;

            // Burst end takes priority so a restart on the last beat cannot
            // leak the abort flag into the next burst.
            if (burst_end)        abort <= 1'b0;
            else if (abort_start) abort <= 1'b1;

            if (frame_start) begin
                addr <= BASE;
            end else if (burst_end && !abort) begin
                if (addr_inc == END_ADDR) begin
                    addr       <= BASE;
                    frame_done <= 1'b1;
                end else begin
                    addr <= addr_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed-sequence bench with randomized pixel data; expected values come
// from a queue-based model of the FIFO and a plain integer frame address.
module tb_sdram_frame_writer;

    localparam int BL    = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 24;
    localparam int FW    = 64;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic [15:0]   pix_data = '0;
    logic          frame_start = 1'b0;
    logic          sdram_wr_req;
    logic [AW-1:0] sdram_wr_addr;
    logic          sdram_wr_ack = 1'b0;
    logic [15:0]   sdram_wr_data;
    logic          sdram_wr_next = 1'b0;
    logic          frame_done;
    logic          overflow;
    logic [6:0]    fifo_level;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] q[$];
    int          m_addr = 0;
    bit          m_ovf  = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_frame_writer #(
        .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .ADDR_W(AW),
        .BASE_ADDR(0), .FRAME_WORDS(FW)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .pix_valid(pix_valid), .pix_data(pix_data), .frame_start(frame_start),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_ack(sdram_wr_ack), .sdram_wr_data(sdram_wr_data),
        .sdram_wr_next(sdram_wr_next), .frame_done(frame_done),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: a pixel is kept if there is room, otherwise it is lost.
    task automatic model_push(input logic [15:0] d);
        if (q.size() < DEPTH) q.push_back(d);
        else                  m_ovf = 1;
    endtask

    task automatic push_n(input int n, input bit seq, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = seq ? first + 16'(i) : 16'($urandom);
            model_push(pix_data);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!sdram_wr_req && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", 32'(sdram_wr_req), 32'd1);
    endtask

    // One full burst; optional pixel push on every beat, optional frame
    // restart (with a coincident pixel) just before beat index abort_at.
    task automatic burst(input bit push_too, input int abort_at);
        bit          aborted;
        bit          exp_done;
        logic [15:0] exp;
        wait_req();
        check("req_addr", 32'(sdram_wr_addr), 32'(m_addr));
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
        check("req_drop", 32'(sdram_wr_req), 32'd0);
        aborted = 0;
        for (int b = 0; b < BL; b++) begin
            if (!aborted && b == abort_at) begin
                frame_start = 1'b1;
                pix_valid   = 1'b1;
                pix_data    = 16'($urandom);
                q.delete();
                q.push_back(pix_data);
                m_addr = 0;
                m_ovf  = 0;
                aborted = 1;
                tick();
                frame_start = 1'b0;
                pix_valid   = 1'b0;
                check("flush_level", 32'(fifo_level), 32'd1);
            end
            exp = aborted ? 16'h0000 : q[0];
            check("beat_data", 32'(sdram_wr_data), 32'(exp));
            sdram_wr_next = 1'b1;
            if (!aborted) void'(q.pop_front());
            if (push_too) begin
                pix_valid = 1'b1;
                pix_data  = 16'($urandom);
                model_push(pix_data);
            end
            tick();
            sdram_wr_next = 1'b0;
            pix_valid     = 1'b0;
            if (push_too) check("beat_level", 32'(fifo_level), 32'(q.size()));
        end
        exp_done = 0;
        if (!aborted) begin
            m_addr += BL;
            if (m_addr == FW) begin
                m_addr   = 0;
                exp_done = 1;
            end
        end
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("level", 32'(fifo_level), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req", 32'(sdram_wr_req), 32'd0);
        check("rst_addr", 32'(sdram_wr_addr), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(sdram_wr_data), 32'd0);
        rst = 1'b0;
        tick();

        // Basic burst of 0x0001..0x0008
        push_n(8, 1, 16'h0001);
        check("level8", 32'(fifo_level), 32'd8);
        burst(0, -1);

        // sdram_wr_next outside DATA is ignored
        push_n(4, 0, 16'h0);
        sdram_wr_next = 1'b1;
        tick();
        sdram_wr_next = 1'b0;
        check("next_idle", 32'(fifo_level), 32'd4);
        push_n(4, 0, 16'h0);
        burst(0, -1);
        // Remaining bursts of the 64-word frame; last one pulses frame_done
        for (int k = 0; k < 6; k++) begin
            push_n(8, 0, 16'h0);
            burst(0, -1);
        end
        tick();
        check("done_pulse", 32'(frame_done), 32'd0);

        // Overflow with ack withheld
        push_n(70, 0, 16'h0);
        check("sat_level", 32'(fifo_level), 32'd64);
        check("sat_ovf", 32'(overflow), 32'd1);
        for (int k = 0; k < 8; k++) burst(0, -1);
        frame_start = 1'b1;
        q.delete();
        m_addr = 0;
        m_ovf  = 0;
        tick();
        frame_start = 1'b0;
        check("fs_ovf", 32'(overflow), 32'd0);
        check("fs_level", 32'(fifo_level), 32'd0);

        // Frame restart after 3 beats, then the first post-restart burst
        push_n(8, 0, 16'h0);
        burst(0, 3);
        push_n(7, 0, 16'h0);
        burst(0, -1);

        // Full FIFO with simultaneous push and pop, then drain
        push_n(64, 0, 16'h0);
        check("full_level", 32'(fifo_level), 32'd64);
        burst(1, -1);
        for (int k = 0; k < 8; k++) burst(0, -1);

        // Asynchronous reset in the middle of a burst
        push_n(8, 0, 16'h0);
        wait_req();
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            check("pre_rst_data", 32'(sdram_wr_data), 32'(q[0]));
            void'(q.pop_front());
            sdram_wr_next = 1'b1;
            tick();
        end
        sdram_wr_next = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(sdram_wr_req), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_addr", 32'(sdram_wr_addr), 32'd0);
        check("arst_data", 32'(sdram_wr_data), 32'd0);
        q.delete();
        m_addr = 0;
        m_ovf  = 0;
        tick();
        rst = 1'b0;
        tick();
        push_n(8, 0, 16'h0);
        burst(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
